pc_fetch_unit: RTL



---
 rtl/pc_fetch_pkg.sv | 30 +++
 rtl/pc_next_calc.sv | 58 +++++
 rtl/pc_fetch_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_pkg
// Shared definitions for the MIPS fetch stage:
//   - fetch_state_t : BOOT / RUN / HALT state encoding
//   - OP_*          : primary opcode values seen by the downstream decoder
//   - DEFAULT_HALT_WORD : encoding that stops fetch
//   - jump_target() : pseudo-direct jump address formation
// Optional feature macro used by this slice: FETCH_TAKEN_CNT_EN.
// ---------------------------------------------------------------------------
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [5:0]  OP_RTYPE = 6'b000000;
    localparam logic [5:0]  OP_J     = 6'b000010;
    localparam logic [5:0]  OP_BEQ   = 6'b000100;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    // Pseudo-direct jump: keep the top nibble of PC+4, word-align the index.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] index);
        return {pc_plus4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// ---------------------------------------------------------------------------
// pc_next_calc
// Purely combinational next-PC selection for the fetch stage.
// Ports:
//   i_pc          current PC
//   i_jump_index  instruction[25:0] (jump word index)
//   i_sext_imm    sign-extended instruction[15:0] (branch word offset)
//   i_jump        decoder Jump
//   i_branch      decoder Branch (beq)
//   i_zero        ALU Zero flag
//   o_pc_plus4    PC + 4, wraps modulo 2^32
//   o_next_pc     selected next PC (Jump > Branch&Zero > PC+4)
//   o_redirect    next PC comes from a jump or a taken branch
//   o_range_fault selected next PC lies outside instruction memory
// ---------------------------------------------------------------------------
module pc_next_calc
    import pc_fetch_pkg::*;
#(
    parameter int IMEM_BYTES = 1024
) (
    input  logic [31:0] i_pc,
    input  logic [25:0] i_jump_index,
    input  logic [31:0] i_sext_imm,
    input  logic        i_jump,
    input  logic        i_branch,
    input  logic        i_zero,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_next_pc,
    output logic        o_redirect,
    output logic        o_range_fault
);

    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;

    assign o_pc_plus4      = i_pc + 32'd4;
    assign w_branch_target = o_pc_plus4 + {i_sext_imm[29:0], 2'b00};
    assign w_jump_target   = jump_target(o_pc_plus4, i_jump_index);

    // Next-PC priority mux; Jump wins even if the decoder also raises Branch.
    always_comb begin
        o_next_pc  = o_pc_plus4;
        o_redirect = 1'b0;
        if (i_jump) begin
            o_next_pc  = w_jump_target;
            o_redirect = 1'b1;
        end else if (i_branch && i_zero) begin
            o_next_pc  = w_branch_target;
            o_redirect = 1'b1;
        end else begin
            o_next_pc  = o_pc_plus4;
            o_redirect = 1'b0;
        end
    end

    assign o_range_fault = (o_next_pc >= 32'(IMEM_BYTES));

endmodule

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Fetch stage feeding the main opcode decoder of a single-cycle MIPS core.
// Holds the PC, drives the instruction-memory address, returns the fetched
// word and its opcode, and sequences BOOT -> RUN -> HALT.
// Ports:
//   Clk, Reset          clock (rising edge), synchronous active-high reset
//   Stall               hold PC, state and counters this cycle
//   Jump, Branch, Zero  redirect controls from decoder / ALU
//   SignExtImm          sign-extended branch offset
//   IMemData            combinational instruction-memory read data
//   IMemAddr, PC        current PC
//   Instruction, OpCode fetched word (zero when not Valid) and its [31:26]
//   PCPlus4             PC + 4
//   Valid, Halted       RUN / HALT indication
//   Fault               sticky out-of-range next-PC flag
//   InstrCount          saturating retired-instruction count
//   TakenCount          saturating redirect count (only with FETCH_TAKEN_CNT_EN)
// Optional feature macro: FETCH_TAKEN_CNT_EN.
// ---------------------------------------------------------------------------
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 1024,
    parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD,
    parameter int          CNT_W      = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Jump,
    input  logic             Branch,
    input  logic             Zero,
    input  logic [31:0]      SignExtImm,
    input  logic [31:0]      IMemData,
    output logic [31:0]      IMemAddr,
    output logic [31:0]      Instruction,
    output logic [5:0]       OpCode,
    output logic [31:0]      PC,
    output logic [31:0]      PCPlus4,
    output logic             Valid,
    output logic             Halted,
    output logic             Fault,
`ifdef FETCH_TAKEN_CNT_EN
    output logic [CNT_W-1:0] TakenCount,
`endif
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    fetch_state_t     r_state;
    logic [31:0]      r_pc;
    logic             r_valid;
    logic             r_halted;
    logic             r_fault;
    logic [CNT_W-1:0] r_instr_count;

    logic [31:0]      w_instruction;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_next_pc;
    logic             w_redirect;
    logic             w_range_fault;
    logic             w_advance;
    logic             w_is_halt;

    // Memory read is combinational, so the word is live in the same cycle;
    // outside RUN it is forced to zero so the decoder sees a harmless R-type.
    assign w_instruction = r_valid ? IMemData : 32'h0000_0000;
    assign w_is_halt     = (w_instruction == HALT_WORD);
    assign w_advance     = r_valid && !Stall;

    pc_next_calc #(
        .IMEM_BYTES (IMEM_BYTES)
    ) u_next (
        .i_pc          (r_pc),
        .i_jump_index  (w_instruction[25:0]),
        .i_sext_imm    (SignExtImm),
        .i_jump        (Jump),
        .i_branch      (Branch),
        .i_zero        (Zero),
        .o_pc_plus4    (w_pc_plus4),
        .o_next_pc     (w_next_pc),
        .o_redirect    (w_redirect),
        .o_range_fault (w_range_fault)
    );

    // Fetch FSM: PC, state, status flags and retired-instruction counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_valid       <= 1'b0;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
            r_instr_count <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state  <= ST_RUN;
                    r_valid  <= 1'b1;
                    r_halted <= 1'b0;
                end
                ST_RUN: begin
                    if (!Stall) begin
                        if (w_is_halt) begin
                            // Halt word is not retired and takes precedence
                            // over any fault its redirect might have caused.
                            r_state  <= ST_HALT;
                            r_valid  <= 1'b0;
                            r_halted <= 1'b1;
                        end else begin
                            if (r_instr_count != CNT_MAX) begin
                                r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
                            end else begin
                                r_instr_count <= r_instr_count;
                            end
                            if (w_range_fault) begin
                                // PC stays on the faulting instruction.
                                r_state  <= ST_HALT;
                                r_valid  <= 1'b0;
                                r_halted <= 1'b1;
                                r_fault  <= 1'b1;
                            end else begin
                                r_pc <= w_next_pc;
                            end
                        end
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state  <= ST_HALT;
                    r_valid  <= 1'b0;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

`ifdef FETCH_TAKEN_CNT_EN
    logic [CNT_W-1:0] r_taken_count;
    logic             w_taken;

    // Only redirects that actually load the PC are counted.
    assign w_taken = w_advance && !w_is_halt && !w_range_fault && w_redirect;

    // Saturating count of taken jumps and branches.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_taken_count <= {CNT_W{1'b0}};
        end else if (w_taken && (r_taken_count != CNT_MAX)) begin
            r_taken_count <= r_taken_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_taken_count <= r_taken_count;
        end
    end

    assign TakenCount = r_taken_count;
`else
    logic w_unused_redirect;
    assign w_unused_redirect = w_redirect & w_advance;
`endif

    assign IMemAddr    = r_pc;
    assign PC          = r_pc;
    assign PCPlus4     = w_pc_plus4;
    assign Instruction = w_instruction;
    assign OpCode      = r_valid ? w_instruction[31:26] : OP_RTYPE;
    assign Valid       = r_valid;
    assign Halted      = r_halted;
    assign Fault       = r_fault;
    assign InstrCount  = r_instr_count;

endmodule
